// File: rtl/thread_state_mp.sv
// thread_state_mp: per-thread state store with buffered, arbitrated write channels,
// replicated read copies, a post-reset init sweep and a sticky protocol error.
module thread_state_mp #(
  parameter int N_THREADS   = 16,
  parameter int STATE_WIDTH = 4,
  parameter int N_WR        = 4,
  parameter int N_RD        = 4,
  parameter int RD0_ASYNC   = 1,
  parameter int ARB_MODE    = 0,
  parameter int INIT_STATE  = 0,
  localparam int N_THREADS_MSB = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0
) (
  input  logic                                 CLK,
  input  logic                                 RESET_N,
  input  logic [N_WR-1:0]                      wr_en,
  input  logic [N_WR*(N_THREADS_MSB+1)-1:0]    wr_num,
  input  logic [N_WR*STATE_WIDTH-1:0]          wr_state,
  output logic [N_WR-1:0]                      wr_rdy,
  input  logic [N_RD*(N_THREADS_MSB+1)-1:0]    rd_num,
  output logic [N_RD*STATE_WIDTH-1:0]          rd_state,
  output logic                                 init_done,
  output logic [N_WR-1:0]                      pending,
  output logic                                 err
);
  localparam int IW = N_THREADS_MSB + 1;
  localparam int PW = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int NC = (N_RD + 1) / 2;
  localparam int SW = STATE_WIDTH;
  logic [N_WR-1:0] hold_v, grant;
  logic [IW-1:0]   hold_num [N_WR];
  logic [SW-1:0]   hold_st [N_WR];
  logic [SW-1:0]   mem [NC][N_THREADS];
  logic [SW-1:0]   rd_q [N_RD];
  logic [IW-1:0]   sweep, wa;
  logic [SW-1:0]   wd;
  logic [PW-1:0]   ptr, gidx, idx;
  logic            gv;
  // Scan from the highest search offset down so the lowest offset wins.
  always_comb begin
    gv = 1'b0;
    gidx = '0;
    idx = '0;
    for (int k = N_WR - 1; k >= 0; k--) begin
      idx = (ARB_MODE != 0) ? PW'((int'(ptr) + k) % N_WR) : PW'(k);
      gv = hold_v[idx] ? 1'b1 : gv;
      gidx = hold_v[idx] ? idx : gidx;
    end
  end
  assign grant   = gv ? N_WR'(1) << gidx : '0;
  assign wr_rdy  = {N_WR{init_done}} & (~hold_v | grant);
  assign pending = hold_v;
  assign wa      = init_done ? hold_num[gidx] : sweep;
  assign wd      = init_done ? hold_st[gidx] : SW'(INIT_STATE);
  // Memory is never reset so it stays mappable to distributed RAM.
  always_ff @(posedge CLK)
    if (RESET_N && (gv || !init_done))
      for (int c = 0; c < NC; c++) mem[c][wa] <= wd;
  always_ff @(posedge CLK)
    for (int i = 0; i < N_WR; i++)
      if (wr_en[i] && wr_rdy[i]) begin
        hold_num[i] <= wr_num[i*IW +: IW];
        hold_st[i]  <= wr_state[i*SW +: SW];
      end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hold_v    <= '0;
      err       <= 1'b0;
      sweep     <= '0;
      init_done <= 1'b0;
      ptr       <= '0;
      for (int j = 0; j < N_RD; j++) rd_q[j] <= '0;
    end else begin
      if (!init_done) begin
        sweep     <= sweep + 1'b1;
        init_done <= (sweep == IW'(N_THREADS - 1));
      end
      if (gv) ptr <= (gidx == PW'(N_WR - 1)) ? '0 : gidx + 1'b1;
      hold_v <= (hold_v & ~grant) | (wr_en & wr_rdy);
      if (|(wr_en & ~wr_rdy)) err <= 1'b1;
      for (int j = 0; j < N_RD; j++) rd_q[j] <= mem[j/2][rd_num[j*IW +: IW]];
    end
  end
  for (genvar j = 0; j < N_RD; j++) begin : g_rd
    if (j == 0 && RD0_ASYNC != 0) begin : g_async
      assign rd_state[j*SW +: SW] = mem[0][rd_num[IW-1:0]];
    end else begin : g_reg
      assign rd_state[j*SW +: SW] = rd_q[j];
    end
  end
endmodule

// File: tb/tb_thread_state_mp.sv
// tb_thread_state_mp: fixed-priority and round-robin instances driven side by side,
// checked each cycle against a queue of expectations from a behavioural model.
module tb_thread_state_mp;
  localparam int NT = 16, SW = 4, NW = 4, NR = 4, IW = 4, INIT = 5;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic [NW-1:0]    wr_en [2];
  logic [NW*IW-1:0] wr_num [2];
  logic [NW*SW-1:0] wr_state [2];
  logic [NW-1:0]    wr_rdy [2];
  logic [NW-1:0]    pending [2];
  logic [NR*SW-1:0] rd_state [2];
  logic             init_done [2];
  logic             err [2];
  logic [NR*IW-1:0] rd_num;
  int n_cmp = 0, n_bad = 0, mode = 0;
  int cnt [2][NW];
  always #5 CLK = ~CLK;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    thread_state_mp #(.N_THREADS(NT), .STATE_WIDTH(SW), .N_WR(NW), .N_RD(NR),
                      .RD0_ASYNC(1), .ARB_MODE(m), .INIT_STATE(INIT)) u_dut (
      .CLK(CLK), .RESET_N(RESET_N), .wr_en(wr_en[m]), .wr_num(wr_num[m]),
      .wr_state(wr_state[m]), .wr_rdy(wr_rdy[m]), .rd_num(rd_num),
      .rd_state(rd_state[m]), .init_done(init_done[m]), .pending(pending[m]), .err(err[m]));
  end

  // Reference model: per-instance slots, pointer, sweep progress and memory image.
  int mk [2], mptr [2], mmem [2][NT], mhn [2][NW], mhs [2][NW], mreg [2][NR];
  bit mi [2], merr [2], mrv [2], mhv [2][NW];

  typedef struct {
    int m;
    logic [NW-1:0] rdy, pend;
    logic init, er, rv, av;
    int rd [NR];
  } exp_t;
  exp_t sb [$];

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int m_grant(int m);
    for (int o = 0; o < NW; o++) begin
      int c;
      c = (m == 1) ? (mptr[m] + o) % NW : o;
      if (mhv[m][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NW-1:0] m_rdy(int m);
    logic [NW-1:0] r;
    int g;
    g = m_grant(m);
    for (int i = 0; i < NW; i++) r[i] = mi[m] && (!mhv[m][i] || g == i);
    return r;
  endfunction

  task automatic m_edge(int m);
    logic [NW-1:0] r;
    int g;
    mrv[m] = RESET_N && mi[m];
    for (int j = 0; j < NR; j++) mreg[m][j] = mmem[m][rd_num[j*IW +: IW]];
    if (!RESET_N) begin
      mk[m] = 0; mi[m] = 0; merr[m] = 0; mptr[m] = 0;
      for (int i = 0; i < NW; i++) mhv[m][i] = 0;
    end else if (!mi[m]) begin
      mmem[m][mk[m]] = INIT;
      if (wr_en[m] != 0) merr[m] = 1;
      mk[m]++;
      mi[m] = (mk[m] == NT);
    end else begin
      r = m_rdy(m);
      g = m_grant(m);
      if ((wr_en[m] & ~r) != 0) merr[m] = 1;
      if (g >= 0) begin
        mmem[m][mhn[m][g]] = mhs[m][g];
        mhv[m][g] = 0;
        mptr[m] = (g + 1) % NW;
      end
      for (int i = 0; i < NW; i++)
        if (wr_en[m][i] && r[i]) begin
          mhv[m][i] = 1;
          mhn[m][i] = int'(wr_num[m][i*IW +: IW]);
          mhs[m][i] = int'(wr_state[m][i*SW +: SW]);
        end
    end
  endtask

  task automatic clk_step();
    @(posedge CLK);
    #1;
    for (int m = 0; m < 2; m++) m_edge(m);
  endtask

  task automatic push_exp();
    for (int m = 0; m < 2; m++) begin
      exp_t e;
      e.m = m;
      e.rdy = m_rdy(m);
      for (int i = 0; i < NW; i++) e.pend[i] = mhv[m][i];
      e.init = mi[m];
      e.er = merr[m];
      e.rv = mrv[m];
      e.av = mi[m];
      e.rd[0] = mmem[m][rd_num[IW-1:0]];
      for (int j = 1; j < NR; j++) e.rd[j] = mreg[m][j];
      sb.push_back(e);
    end
  endtask

  task automatic drive();
    logic [NW-1:0] r;
    if (mode == 0) return;
    rd_num = (NR*IW)'($urandom);
    for (int m = 0; m < 2; m++) begin
      r = m_rdy(m);
      wr_num[m] = (NW*IW)'($urandom);
      wr_state[m] = (NW*SW)'($urandom);
      case (mode)
        1: wr_en[m] = '0;
        2: wr_en[m] = r & NW'($urandom);
        3: wr_en[m] = r;
        default: wr_en[m] = (r & NW'(1)) | NW'(2);
      endcase
    end
  endtask

  task automatic tick();
    clk_step();
    drive();
    push_exp();
  endtask

  task automatic wait_init(string nm);
    int n;
    n = 0;
    while (!init_done[0] && n < 40) begin
      tick();
      n++;
    end
    check(nm, n, 16);
    check({nm, "_rr"}, init_done[1], 1);
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("wr_rdy%0d", e.m), wr_rdy[e.m], e.rdy);
      check($sformatf("pending%0d", e.m), pending[e.m], e.pend);
      check($sformatf("init_done%0d", e.m), init_done[e.m], e.init);
      check($sformatf("err%0d", e.m), err[e.m], e.er);
      if (e.av) check($sformatf("rd0_async%0d", e.m), rd_state[e.m][SW-1:0], e.rd[0]);
      if (e.rv)
        for (int j = 1; j < NR; j++)
          check($sformatf("rd%0d_reg%0d", j, e.m), rd_state[e.m][j*SW +: SW], e.rd[j]);
    end
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      wr_en[m] = '0; wr_num[m] = '0; wr_state[m] = '0;
      mk[m] = 0; mi[m] = 0; merr[m] = 0; mptr[m] = 0;
      for (int i = 0; i < NW; i++) mhv[m][i] = 0;
      for (int k = 0; k < NT; k++) mmem[m][k] = -1;
    end
    rd_num = '0;
    repeat (2) begin clk_step(); push_exp(); end
    clk_step(); RESET_N = 1'b1; push_exp();
    mode = 1;
    wait_init("init_latency");
    mode = 0;
    for (int k = 0; k < NT; k++) begin clk_step(); rd_num = {NR{IW'(k)}}; push_exp(); end
    tick();
    // Two channels written in the same cycle.
    clk_step();
    for (int m = 0; m < 2; m++) begin
      wr_en[m] = 4'b0101;
      wr_num[m] = {4'd0, 4'd7, 4'd0, 4'd3};
      wr_state[m] = {4'h0, 4'hC, 4'h0, 4'hA};
    end
    rd_num = {4'd3, 4'd7, 4'd3, 4'd7};
    push_exp();
    clk_step();
    for (int m = 0; m < 2; m++) wr_en[m] = '0;
    push_exp();
    check("ac_rdy2_busy", wr_rdy[0][2], 0);
    repeat (4) tick();
    check("ac_read3", rd_state[0][7:4], 4'hA);
    check("ac_read7", rd_state[0][11:8], 4'hC);
    check("ac_async7", rd_state[0][3:0], 4'hC);
    // Async port 0 against registered port 1, both on index 4.
    clk_step(); rd_num = {NR{4'd4}}; push_exp();
    tick();
    clk_step();
    for (int m = 0; m < 2; m++) begin
      wr_en[m] = 4'b0001; wr_num[m] = 16'h0004; wr_state[m] = 16'h0009;
    end
    push_exp();
    clk_step();
    for (int m = 0; m < 2; m++) wr_en[m] = '0;
    push_exp();
    check("async_before", rd_state[0][3:0], 4'h5);
    tick();
    check("async_t1", rd_state[0][3:0], 4'h9);
    check("reg_t1_old", rd_state[0][7:4], 4'h5);
    tick();
    check("reg_t2_new", rd_state[0][7:4], 4'h9);
    mode = 2;
    repeat (300) tick();
    mode = 1;
    repeat (8) tick();
    // All channels held continuously: share of ready cycles per channel.
    mode = 3;
    repeat (2) tick();
    for (int m = 0; m < 2; m++) for (int i = 0; i < NW; i++) cnt[m][i] = 0;
    repeat (16) begin
      tick();
      for (int m = 0; m < 2; m++) for (int i = 0; i < NW; i++) cnt[m][i] += int'(wr_rdy[m][i]);
    end
    for (int i = 0; i < NW; i++) begin
      check($sformatf("fixed_share%0d", i), cnt[0][i], (i == 0) ? 16 : 0);
      check($sformatf("rr_share%0d", i), cnt[1][i], 4);
    end
    mode = 1;
    repeat (6) tick();
    check("err_clean_fixed", err[0], 0);
    check("err_clean_rr", err[1], 0);
    mode = 4;
    repeat (6) tick();
    mode = 2;
    repeat (40) tick();
    check("err_sticky_fixed", err[0], 1);
    check("err_sticky_rr", err[1], 1);
    // Reset with buffered writes, then a reset pulse in the middle of the sweep.
    mode = 3;
    repeat (2) tick();
    check("pend_before_rst", pending[0], 4'hF);
    clk_step();
    mode = 0;
    for (int m = 0; m < 2; m++) wr_en[m] = '0;
    RESET_N = 1'b0;
    push_exp();
    clk_step(); RESET_N = 1'b1; push_exp();
    check("rst_pending", pending[0], 0);
    check("rst_err", err[0], 0);
    check("rst_err_rr", err[1], 0);
    repeat (6) tick();
    clk_step(); RESET_N = 1'b0; push_exp();
    clk_step(); RESET_N = 1'b1; push_exp();
    mode = 1;
    wait_init("reinit_latency");
    mode = 2;
    repeat (100) tick();
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
